// File: rtl/tqvp_ubcd_scan_driver.sv
// TinyQV 7-segment scan driver: per-digit frames shifted MSB first into a 74HC595-style chain.
// Outputs are registered one clock behind each tick. No backpressure. Macro UBCD_SCAN_RBLANK_EN adds leading-zero blanking.
module tqvp_ubcd_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int HOLD_TICKS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT_L = 3'd2,
        S_SHIFT_H = 3'd3,
        S_LATCH   = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    localparam logic [3:0]  LP_ND   = 4'(NUM_DIGITS);
    localparam logic [2:0]  LP_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [15:0] LP_HOLD = 16'(HOLD_TICKS - 1);

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_digit [8];
    logic [4:0]  r_ctrl;
    logic [7:0]  r_div, r_pcnt, w_pcnt_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [3:0]  r_bitcnt, w_bitcnt_nxt;
    logic [15:0] r_hold, w_hold_nxt;
    logic [15:0] r_frame, w_frame_nxt, w_frame;
    logic        r_ser, r_srclk, r_rclk;
    logic        w_ser_nxt, w_srclk_nxt, w_rclk_nxt;
    logic        w_tick, w_blank, w_rbe;
    logic [4:0]  w_sel;
    logic [7:0]  w_seg, w_dig;
    logic        w_unused;

    assign w_unused = &{1'b0, data_in[7:5]};

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
            4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
            4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
            4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
        endcase
    endfunction

`ifdef UBCD_SCAN_RBLANK_EN
    assign w_rbe = data_in[4];
`else
    assign w_rbe = 1'b0;
`endif

    // Register file; digit slots at or above NUM_DIGITS are never written and fold to constants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_digit[i] <= '0;
            r_ctrl <= '0;
            r_div  <= '0;
        end else if (data_write) begin
            if (address < LP_ND)       r_digit[address[2:0]] <= data_in[4:0];
            else if (address == 4'h8)  r_ctrl <= {w_rbe, data_in[3:0]};
            else if (address == 4'h9)  r_div  <= data_in;
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h8:    data_out = {3'b000, r_ctrl};
            4'h9:    data_out = r_div;
            4'hA:    data_out = {r_state != S_IDLE, 1'b0, r_state, r_idx};
            4'hF:    data_out = ui_in;
            default: if (address < LP_ND) data_out = {3'b000, r_digit[address[2:0]]};
        endcase
    end

    // Frame built from live registers; capturing it at LOAD is the snapshot.
    always_comb begin
        w_sel   = r_digit[r_idx];
        w_blank = 1'b0;
`ifdef UBCD_SCAN_RBLANK_EN
        if (r_ctrl[4] && r_idx != 3'd0 && w_sel == 5'd0) begin
            w_blank = 1'b1;
            for (int j = 1; j < 8; j++)
                if (j < NUM_DIGITS && j > int'(r_idx) && r_digit[j][3:0] != 4'd0) w_blank = 1'b0;
        end
`endif
        if (w_blank)                               w_seg = 8'h00;
        else if (r_ctrl[3] || w_sel[3:0] < 4'd10)  w_seg = {w_sel[4], font(w_sel[3:0])};
        else                                       w_seg = {w_sel[4], 7'h00};
        w_dig   = 8'h01 << r_idx;
        w_frame = {r_ctrl[2] ? ~w_dig : w_dig, r_ctrl[1] ? ~w_seg : w_seg};
    end

    assign w_tick = (r_state != S_IDLE) && (r_pcnt >= r_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pcnt   <= '0;
            r_idx    <= '0;
            r_bitcnt <= '0;
            r_hold   <= '0;
            r_frame  <= '0;
            r_ser    <= 1'b0;
            r_srclk  <= 1'b0;
            r_rclk   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pcnt   <= w_pcnt_nxt;
            r_idx    <= w_idx_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_hold   <= w_hold_nxt;
            r_frame  <= w_frame_nxt;
            r_ser    <= w_ser_nxt;
            r_srclk  <= w_srclk_nxt;
            r_rclk   <= w_rclk_nxt;
        end
    end

    // Pin values are computed for the state being entered, so they register alongside it.
    always_comb begin
        w_state_nxt  = r_state;
        w_pcnt_nxt   = w_tick ? 8'd0 : r_pcnt + 8'd1;
        w_idx_nxt    = r_idx;
        w_bitcnt_nxt = r_bitcnt;
        w_hold_nxt   = r_hold;
        w_frame_nxt  = r_frame;
        w_ser_nxt    = r_ser;
        w_srclk_nxt  = r_srclk;
        w_rclk_nxt   = r_rclk;
        if (r_state == S_IDLE || !r_ctrl[0]) begin
            w_state_nxt = (r_state == S_IDLE && r_ctrl[0]) ? S_LOAD : S_IDLE;
            w_pcnt_nxt  = 8'd0;
            w_idx_nxt   = 3'd0;
            w_ser_nxt   = 1'b0;
            w_srclk_nxt = 1'b0;
            w_rclk_nxt  = 1'b0;
        end else if (w_tick) begin
            case (r_state)
                S_LOAD: begin
                    w_frame_nxt  = w_frame;
                    w_bitcnt_nxt = 4'd15;
                    w_ser_nxt    = w_frame[15];
                    w_srclk_nxt  = 1'b0;
                    w_state_nxt  = S_SHIFT_L;
                end
                S_SHIFT_L: begin
                    w_srclk_nxt = 1'b1;
                    w_state_nxt = S_SHIFT_H;
                end
                S_SHIFT_H: begin
                    w_srclk_nxt = 1'b0;
                    if (r_bitcnt == 4'd0) begin
                        w_ser_nxt   = 1'b0;
                        w_rclk_nxt  = 1'b1;
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt - 4'd1;
                        w_ser_nxt    = r_frame[r_bitcnt - 4'd1];
                        w_state_nxt  = S_SHIFT_L;
                    end
                end
                S_LATCH: begin
                    w_rclk_nxt  = 1'b0;
                    w_hold_nxt  = LP_HOLD;
                    w_state_nxt = S_HOLD;
                end
                S_HOLD: begin
                    if (r_hold == 16'd0) begin
                        w_idx_nxt   = (r_idx == LP_LAST) ? 3'd0 : r_idx + 3'd1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_hold_nxt = r_hold - 16'd1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign uo_out = {4'b0000, r_rclk, r_srclk, r_ser, 1'b0};
endmodule
